// File: rtl/fma_sched_pkg.sv
// Shared types and constants for the FMA job scheduler and its datapath.
package fma_sched_pkg;

  typedef logic [31:0] word_t;
  typedef logic [15:0] half_t;

  localparam int LEN_W_DEF = 8;
  localparam int NUM_REQ   = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    RESP
  } state_e;

  // One beat's contribution to the accumulator: unsigned m*x + c, kept to 32 bits.
  function automatic word_t mac_term(input half_t m, input half_t x, input half_t c);
    return (word_t'(m) * word_t'(x)) + word_t'(c);
  endfunction

endpackage

// File: rtl/fma_job_scheduler_fused_multiply_add.sv
// Multiply-accumulate datapath: load a start value, then add m*x + c on each pass.
module fused_multiply_add
  import fma_sched_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  cntrl_load,
  input  word_t cntrl_init,
  input  logic  pass,
  input  half_t m,
  input  half_t x,
  input  half_t c,
  output word_t sum
);

  word_t acc_q;
  word_t acc_d;

  // Next accumulator value: load wins over pass, otherwise hold.
  always_comb begin
    acc_d = acc_q;
    if (cntrl_load) begin
      acc_d = cntrl_init;
    end else if (pass) begin
      acc_d = acc_q + mac_term(m, x, c);
    end
  end

  // Accumulator register; wraps modulo 2^32.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sum = acc_q;

endmodule

// File: rtl/fma_job_scheduler.sv
// Two-requester round-robin job scheduler sharing one multiply-accumulate datapath.
module fma_job_scheduler
  import fma_sched_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_init,
  input  logic [LEN_W-1:0] req0_len,
  input  logic             op0_valid,
  output logic             op0_ready,
  input  logic [15:0]      op0_m,
  input  logic [15:0]      op0_x,
  input  logic [15:0]      op0_c,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_y,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_init,
  input  logic [LEN_W-1:0] req1_len,
  input  logic             op1_valid,
  output logic             op1_ready,
  input  logic [15:0]      op1_m,
  input  logic [15:0]      op1_x,
  input  logic [15:0]      op1_c,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_y,
  // status
  output logic             busy,
  output logic             owner
);

  // Requester-indexed views of the ports so the FSM can select by owner.
  logic [NUM_REQ-1:0] req_valid_v;
  logic [NUM_REQ-1:0] op_valid_v;
  logic [NUM_REQ-1:0] rsp_ready_v;
  word_t              req_init_v [NUM_REQ];
  logic [LEN_W-1:0]   req_len_v  [NUM_REQ];

  assign req_valid_v   = {req1_valid, req0_valid};
  assign op_valid_v    = {op1_valid, op0_valid};
  assign rsp_ready_v   = {rsp1_ready, rsp0_ready};
  assign req_init_v[0] = req0_init;
  assign req_init_v[1] = req1_init;
  assign req_len_v[0]  = req0_len;
  assign req_len_v[1]  = req1_len;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  word_t            init_q, init_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  word_t            rsp_y_q, rsp_y_d;

  logic [NUM_REQ-1:0] req_ready_v;
  logic [NUM_REQ-1:0] op_ready_v;
  logic [NUM_REQ-1:0] rsp_valid_v;

  logic  dp_load;
  logic  dp_pass;
  word_t dp_sum;

  // FSM next state, arbitration, job capture and per-requester handshakes.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    init_d      = init_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    rsp_y_d     = rsp_y_q;
    req_ready_v = '0;
    op_ready_v  = '0;
    rsp_valid_v = '0;
    dp_load     = 1'b0;
    dp_pass     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Both valid: the rr pointer decides; one valid: that one wins.
        if (rst_n && (req_valid_v != '0)) begin
          owner_d              = (&req_valid_v) ? rr_q : req_valid_v[1];
          req_ready_v[owner_d] = 1'b1;
          init_d               = req_init_v[owner_d];
          len_d                = req_len_v[owner_d];
          state_d              = LOAD;
        end
      end
      LOAD: begin
        dp_load = 1'b1;
        cnt_d   = '0;
        state_d = (len_q != '0) ? RUN : DRAIN;
      end
      RUN: begin
        op_ready_v[owner_q] = 1'b1;
        if (op_valid_v[owner_q]) begin
          dp_pass = 1'b1;
          cnt_d   = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        rsp_y_d = dp_sum;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid_v[owner_q] = 1'b1;
        if (rsp_ready_v[owner_q]) begin
          rr_d    = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and job registers; reset drops any job in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      init_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rsp_y_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      init_q  <= init_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rsp_y_q <= rsp_y_d;
    end
  end

  fused_multiply_add u_fma (
    .clk        (clk),
    .rst_n      (rst_n),
    .cntrl_load (dp_load),
    .cntrl_init (init_q),
    .pass       (dp_pass),
    .m          (owner_q ? op1_m : op0_m),
    .x          (owner_q ? op1_x : op0_x),
    .c          (owner_q ? op1_c : op0_c),
    .sum        (dp_sum)
  );

  assign req0_ready = req_ready_v[0];
  assign req1_ready = req_ready_v[1];
  assign op0_ready  = op_ready_v[0];
  assign op1_ready  = op_ready_v[1];
  assign rsp0_valid = rsp_valid_v[0];
  assign rsp1_valid = rsp_valid_v[1];
  assign rsp0_y     = rsp_y_q;
  assign rsp1_y     = rsp_y_q;
  assign busy       = (state_q != IDLE);
  assign owner      = owner_q;

endmodule

// File: tb/tb_fma_job_scheduler.sv
// Self-checking bench for fma_job_scheduler: directed vectors, corner sequences, random jobs.
module tb_fma_job_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_ready, op_valid, op_ready, rsp_valid, rsp_ready;
  logic [1:0][31:0] req_init, rsp_y;
  logic [1:0][7:0]  req_len;
  logic [1:0][15:0] op_m, op_x, op_c;
  logic             busy, owner;

  fma_job_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req_valid[0]), .req0_ready (req_ready[0]),
    .req0_init  (req_init[0]),  .req0_len   (req_len[0]),
    .op0_valid  (op_valid[0]),  .op0_ready  (op_ready[0]),
    .op0_m      (op_m[0]),      .op0_x      (op_x[0]),      .op0_c (op_c[0]),
    .rsp0_valid (rsp_valid[0]), .rsp0_ready (rsp_ready[0]), .rsp0_y (rsp_y[0]),
    .req1_valid (req_valid[1]), .req1_ready (req_ready[1]),
    .req1_init  (req_init[1]),  .req1_len   (req_len[1]),
    .op1_valid  (op_valid[1]),  .op1_ready  (op_ready[1]),
    .op1_m      (op_m[1]),      .op1_x      (op_x[1]),      .op1_c (op_c[1]),
    .rsp1_valid (rsp_valid[1]), .rsp1_ready (rsp_ready[1]), .rsp1_y (rsp_y[1]),
    .busy       (busy),
    .owner      (owner)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Beat operands for the job currently being driven.
  logic [15:0] bm [8];
  logic [15:0] bx [8];
  logic [15:0] bc [8];

  typedef struct {
    int          r;
    logic [31:0] init;
    int          len;
    logic [15:0] m0, x0, c0, m1, x1, c1;
    int          gap;
    int          rdly;
    logic [31:0] exp_y;
    int          exp_lat;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_gap(input int mode, input int it);
    if (mode == 1) return (it % 2) == 1;
    if (mode == 2) return $urandom_range(0, 3) == 0;
    return 1'b0;
  endfunction

  // Reference result straight from the arithmetic definition.
  function automatic logic [31:0] model_y(input logic [31:0] init, input int len);
    logic [31:0] e;
    e = init;
    for (int k = 0; k < len; k++) begin
      e = e + ({16'h0, bm[k]} * {16'h0, bx[k]}) + {16'h0, bc[k]};
    end
    return e;
  endfunction

  // Runs one full job on requester r: grant, beats, response, handshake.
  task automatic do_job(input string nm, input int r, input logic [31:0] init, input int len,
                        input int gap_mode, input int rdly, input logic [31:0] exp_y,
                        input int exp_lat);
    int g, k, opr_cnt, nonown_bad, stable_bad;
    bit hit;
    logic [31:0] y0;
    req_valid[r] = 1'b1;
    req_init[r]  = init;
    req_len[r]   = 8'(len);
    hit = 1'b0;
    for (int w = 0; w < 50 && !hit; w++) begin
      #1;
      if (req_ready[r]) hit = 1'b1;
      else tick();
    end
    check({nm, ".grant"}, 32'(hit), 32'd1);
    g = cyc;
    tick();
    req_valid[r] = 1'b0;
    #1;
    check({nm, ".owner"}, 32'(owner), 32'(r));
    check({nm, ".busy"}, 32'(busy), 32'd1);
    k = 0; opr_cnt = 0; nonown_bad = 0; hit = 1'b0;
    for (int it = 0; it < 300 && !hit; it++) begin
      op_valid[r] = (k < len) && !is_gap(gap_mode, it);
      op_m[r] = bm[k % 8];
      op_x[r] = bx[k % 8];
      op_c[r] = bc[k % 8];
      #1;
      if (rsp_valid[r]) begin
        hit = 1'b1;
      end else begin
        if (op_ready[1-r] || rsp_valid[1-r]) nonown_bad++;
        if (op_ready[r]) opr_cnt++;
        if (op_valid[r] && op_ready[r]) k++;
        tick();
      end
    end
    op_valid[r] = 1'b0;
    check({nm, ".rsp_valid"}, 32'(hit), 32'd1);
    check({nm, ".beats"}, 32'(k), 32'(len));
    check({nm, ".nonowner_quiet"}, 32'(nonown_bad), 32'd0);
    if (gap_mode == 0) check({nm, ".op_ready_cycles"}, 32'(opr_cnt), 32'(len));
    if (exp_lat >= 0) check({nm, ".latency"}, 32'(cyc - g), 32'(exp_lat));
    check({nm, ".rsp_y"}, rsp_y[r], exp_y);
    y0 = rsp_y[r];
    stable_bad = 0;
    for (int d = 0; d < rdly; d++) begin
      tick();
      #1;
      if (!rsp_valid[r] || rsp_y[r] !== y0 || op_ready[1-r]) stable_bad++;
    end
    if (rdly > 0) check({nm, ".rsp_hold"}, 32'(stable_bad), 32'd0);
    rsp_ready[r] = 1'b1;
    tick();
    rsp_ready[r] = 1'b0;
    #1;
    check({nm, ".idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int bad;
    bit hit;
    logic [31:0] e;
    int r, len, gm;

    req_valid = '0; req_init = '0; req_len = '0;
    op_valid = '0; op_m = '0; op_x = '0; op_c = '0; rsp_ready = '0;
    rst_n = 1'b0;

    vecs[0] = '{r: 0, init: 32'd5, len: 2, m0: 16'd3, x0: 16'd4, c0: 16'd1,
                m1: 16'd2, x1: 16'd10, c1: 16'd0, gap: 0, rdly: 0, exp_y: 32'd38, exp_lat: 5};
    vecs[1] = '{r: 1, init: 32'hDEADBEEF, len: 0, m0: 16'h1234, x0: 16'h5678, c0: 16'h9,
                m1: 16'h0, x1: 16'h0, c1: 16'h0, gap: 0, rdly: 2, exp_y: 32'hDEADBEEF, exp_lat: 3};
    vecs[2] = '{r: 0, init: 32'hFFFFFFFF, len: 1, m0: 16'hFFFF, x0: 16'hFFFF, c0: 16'hFFFF,
                m1: 16'h0, x1: 16'h0, c1: 16'h0, gap: 0, rdly: 0, exp_y: 32'hFFFEFFFF, exp_lat: 4};
    vecs[3] = '{r: 1, init: 32'd100, len: 2, m0: 16'd7, x0: 16'd8, c0: 16'd9,
                m1: 16'd10, x1: 16'd11, c1: 16'd12, gap: 1, rdly: 10, exp_y: 32'd287, exp_lat: -1};

    // Reset state, with a request held during reset that must not be granted.
    req_valid[0] = 1'b1;
    tick(); tick();
    check("rst.req_ready", 32'(req_ready), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.owner", 32'(owner), 32'd0);
    check("rst.op_ready", 32'(op_ready), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_y", rsp_y[0], 32'd0);
    req_valid[0] = 1'b0;
    rst_n = 1'b1;
    tick();

    // Both requesters valid after reset: req0 first, req1 on the first IDLE cycle after rsp0.
    req_valid = 2'b11;
    req_init[0] = 32'd11; req_len[0] = 8'd0;
    req_init[1] = 32'd22; req_len[1] = 8'd0;
    #1;
    check("rr.first_grant", 32'(req_ready), 32'b01);
    tick();
    req_valid[0] = 1'b0;
    bad = 0; hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      #1;
      if (rsp_valid[0]) hit = 1'b1;
      else begin
        if (req_ready[1]) bad++;
        tick();
      end
    end
    check("rr.rsp0_valid", 32'(hit), 32'd1);
    check("rr.req1_blocked", 32'(bad), 32'd0);
    check("rr.rsp0_y", rsp_y[0], 32'd11);
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    #1;
    check("rr.second_grant", 32'(req_ready), 32'b10);
    do_job("rr.req1", 1, 32'd22, 0, 0, 0, 32'd22, 3);

    // Directed vector table.
    foreach (vecs[i]) begin
      bm[0] = vecs[i].m0; bx[0] = vecs[i].x0; bc[0] = vecs[i].c0;
      bm[1] = vecs[i].m1; bx[1] = vecs[i].x1; bc[1] = vecs[i].c1;
      do_job($sformatf("vec%0d", i), vecs[i].r, vecs[i].init, vecs[i].len,
             vecs[i].gap, vecs[i].rdly, vecs[i].exp_y, vecs[i].exp_lat);
    end

    // Reset in the middle of RUN drops the job; the next job starts clean.
    bm[0] = 16'd9; bx[0] = 16'd9; bc[0] = 16'd9;
    req_valid[1] = 1'b1; req_init[1] = 32'd123; req_len[1] = 8'd3;
    #1;
    check("midrst.grant", 32'(req_ready[1]), 32'd1);
    tick();
    req_valid[1] = 1'b0;
    tick();
    op_valid[1] = 1'b1; op_m[1] = bm[0]; op_x[1] = bx[0]; op_c[1] = bc[0];
    tick();
    #1;
    check("midrst.in_run", 32'(op_ready[1]), 32'd1);
    rst_n = 1'b0;
    tick();
    check("midrst.idle", 32'(busy), 32'd0);
    check("midrst.outputs_low", 32'({op_ready, rsp_valid}), 32'd0);
    rst_n = 1'b1;
    op_valid[1] = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid != 2'b00 || busy) bad++;
    end
    check("midrst.no_rsp", 32'(bad), 32'd0);
    bm[0] = 16'd1; bx[0] = 16'd1; bc[0] = 16'd0;
    do_job("midrst.next", 0, 32'd7, 1, 0, 0, 32'd8, 4);

    // Random jobs against the arithmetic model.
    for (int j = 0; j < 40; j++) begin
      r   = $urandom_range(0, 1);
      len = $urandom_range(0, 7);
      gm  = ($urandom_range(0, 9) < 3) ? 2 : 0;
      for (int k = 0; k < 8; k++) begin
        bm[k] = 16'($urandom); bx[k] = 16'($urandom); bc[k] = 16'($urandom);
      end
      e = $urandom;
      do_job($sformatf("rnd%0d", j), r, e, len, gm, $urandom_range(0, 3),
             model_y(e, len), (gm == 0) ? 3 + len : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fma_job_scheduler.md
FMA_JOB_SCHEDULER -- requirements
Module: fma_job_scheduler

Interface
REQ-001 SHALL have parameter LEN_W, default 8, meaning the width of the job beat count.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have, for each requester i in {0,1}, port req<i>_valid  input  1  job request.
REQ-005 SHALL have req<i>_ready  output  1  job accepted this cycle.
REQ-006 SHALL have req<i>_init  input  32  accumulator start value.
REQ-007 SHALL have req<i>_len  input  LEN_W  operand beat count; 0 is legal.
REQ-008 SHALL have op<i>_valid  input  1, op<i>_ready  output  1, and op<i>_m, op<i>_x, op<i>_c  input  16 each, forming the operand beat stream.
REQ-009 SHALL have rsp<i>_valid  output  1, rsp<i>_ready  input  1, and rsp<i>_y  output  32, forming the result channel.
REQ-010 SHALL have busy  output  1  (state != IDLE) and owner  output  1  (requester index of the current job).

Function
REQ-011 SHALL compute result = init + sum over beats of (m*x + c), unsigned, modulo 2^32.
REQ-012 SHALL use an FSM with states IDLE, LOAD, RUN, DRAIN and RESP.
REQ-013 IDLE: SHALL grant one valid requester per cycle, round-robin; rr pointer names the preferred requester; req<owner>_ready is high for exactly one cycle; init and len are captured; next state is LOAD.
REQ-014 In IDLE, a sole valid requester SHALL be granted regardless of the pointer; with no valid requester the FSM stays in IDLE.
REQ-015 LOAD: SHALL assert the datapath load with the captured init and clear the beat counter; next state is RUN if len != 0, else DRAIN.
REQ-016 RUN: op<owner>_ready SHALL be 1 and the non-owner op_ready SHALL be 0; each op_valid&&op_ready beat SHALL assert datapath pass for that cycle.
REQ-017 RUN SHALL exit to DRAIN on the cycle the len-th beat is accepted; op_valid low SHALL stall RUN indefinitely with no accumulation.
REQ-018 DRAIN: SHALL capture the datapath sum into the rsp_y register in one cycle; next state is RESP.
REQ-019 RESP: rsp<owner>_valid SHALL be held high with rsp_y stable until rsp_ready; on the handshake the FSM returns to IDLE and the rr pointer is set to !owner.
REQ-020 rsp_valid SHALL depend only on state, not combinationally on rsp_ready.
REQ-021 Latency SHALL be: grant cycle, LOAD 1 cycle, len beats (1 per cycle at full throughput), DRAIN 1 cycle, then rsp_valid rises; with len=0, rsp_valid rises 3 cycles after the grant.
REQ-022 A requester SHALL NOT be granted again while its own response is pending.
REQ-023 Requests arriving outside IDLE SHALL see req_ready=0 and are not lost; the requester holds valid.

Reset
REQ-024 While rst_n=0 at a clock edge, SHALL force state=IDLE, rr pointer=0, beat counter=0, and all req_ready, op_ready and rsp_valid low, with busy=0 and owner=0; rsp_y SHALL be 0.
REQ-025 Reset mid-job SHALL silently drop the job; no response is issued; the next job's LOAD reinitialises the datapath.

Structure
REQ-026 Package fma_sched_pkg SHALL hold the 32-bit word typedef, the state enum, LEN_W default and the requester count (2).
REQ-027 The block SHALL instantiate exactly one fused_multiply_add as its multiply-accumulate datapath, driving cntrl_load/cntrl_init/pass/m/x/c from the owner's signals and reading the accumulated sum.

Verification
REQ-028 Directed test: req0 with init=5, len=2, beats (m=3,x=4,c=1) and (m=2,x=10,c=0) -> rsp0_y=38, with rsp0_valid 5 cycles after the grant at full throughput.
REQ-029 Directed test: req0 and req1 both valid in IDLE after reset -> req0 granted first and req1 granted on the first IDLE cycle after rsp0 handshake.
REQ-030 Directed test: len=0, init=0xDEADBEEF -> rsp_y=0xDEADBEEF 3 cycles after the grant; op_ready never asserted.
REQ-031 Directed test: m=x=0xFFFF, c=0xFFFF, init=0xFFFFFFFF, len=1 -> rsp_y=0xFFFEFFFF (mod 2^32 wrap).
REQ-032 Directed test: op_valid gaps and rsp_ready held low 10 cycles -> result unchanged, rsp_y stable, and the non-owner op_ready stays 0 throughout.
REQ-033 Directed test: rst_n low during RUN -> IDLE next cycle, no rsp_valid; a following job with init=7, len=1, (1,1,0) -> rsp_y=8.
